// File: rtl/fast_control_rx.sv
// Fast-control receiver: per-byte Hamming(8,4) SECDED decode, command pulses,
// local BX counter with BCR-based lock tracking and saturating error counters.
module fast_control_rx #(
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk_bx,
  input  logic             reset,
  input  logic [15:0]      fc_stream_enc,
  input  logic [11:0]      orb_length,
  input  logic             cnt_clear,
  output logic             bcr,
  output logic             l1a,
  output logic             link_reset,
  output logic             buffer_clear,
  output logic             calib_start,
  output logic [11:0]      bx_id,
  output logic             locked,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count,
  output logic [31:0]      l1a_count,
  output logic [15:0]      misalign_count
);

  localparam int SC_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {ST_UNSYNC, ST_SYNCING, ST_LOCKED} state_t;

  // Returns {ded, sec, data[3:0]} for one {p_all,p3,p2,p1,d3,d2,d1,d0} byte.
  function automatic logic [5:0] hamming_decode(input logic [7:0] b);
    logic [2:0] syn;
    logic       par_bad;
    logic [3:0] d;
    syn[0]  = b[4] ^ b[0] ^ b[1] ^ b[3];
    syn[1]  = b[5] ^ b[0] ^ b[2] ^ b[3];
    syn[2]  = b[6] ^ b[1] ^ b[2] ^ b[3];
    par_bad = ^b;
    d       = b[3:0];
    if (par_bad) begin
      case (syn)
        3'd3:    d[0] = ~d[0];
        3'd5:    d[1] = ~d[1];
        3'd6:    d[2] = ~d[2];
        3'd7:    d[3] = ~d[3];
        default: d    = d;
      endcase
    end else begin
      d = d;
    end
    return {(~par_bad) & (syn != 3'd0), par_bad, d};
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, v} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  logic [15:0]      r_enc;
  logic             r_bcr, r_l1a, r_link_reset, r_buffer_clear, r_calib, r_bit5_prev;
  logic [11:0]      r_bx;
  logic             r_locked;
  logic [CNT_W-1:0] r_sec, r_ded;
  logic [31:0]      r_l1a_cnt;
  logic [15:0]      r_misalign;
  state_t           r_state, w_state_nxt;
  logic [SC_W-1:0]  r_sync_cnt, w_sync_cnt_nxt;
  logic             w_misalign;

  logic [5:0]  w_lo, w_hi;
  logic        w_ded;
  logic [7:0]  w_fc;
  logic [1:0]  w_sec_inc;
  logic [11:0] w_bx_inc, w_bx_free;
  logic        w_bx_wrap;

  assign w_lo      = hamming_decode(r_enc[7:0]);
  assign w_hi      = hamming_decode(r_enc[15:8]);
  assign w_ded     = w_lo[5] | w_hi[5];
  assign w_fc      = w_ded ? 8'h00 : {w_hi[3:0], w_lo[3:0]};
  assign w_sec_inc = w_ded ? 2'd0 : ({1'b0, w_lo[4]} + {1'b0, w_hi[4]});
  // A BCR is correctly placed when the free-running counter is about to wrap.
  assign w_bx_inc  = r_bx + 12'd1;
  assign w_bx_wrap = (w_bx_inc == orb_length);
  assign w_bx_free = w_bx_wrap ? 12'd0 : w_bx_inc;

  // Lock state machine next-state; misplacement only has meaning once a reference exists.
  always_comb begin
    w_state_nxt    = r_state;
    w_sync_cnt_nxt = r_sync_cnt;
    w_misalign     = 1'b0;
    case (r_state)
      ST_UNSYNC: begin
        if (r_bcr) begin
          w_state_nxt    = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_SYNCING;
          w_sync_cnt_nxt = SC_W'(1);
        end else begin
          w_sync_cnt_nxt = '0;
        end
      end
      ST_SYNCING: begin
        if (r_bcr && w_bx_wrap) begin
          if (r_sync_cnt >= SC_W'(LOCK_COUNT - 1)) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_sync_cnt_nxt = r_sync_cnt + SC_W'(1);
          end
        end else if (r_bcr) begin
          w_state_nxt    = ST_UNSYNC;
          w_sync_cnt_nxt = '0;
          w_misalign     = 1'b1;
        end else begin
          w_state_nxt = ST_SYNCING;
        end
      end
      ST_LOCKED: begin
        if (r_bcr && !w_bx_wrap) begin
          w_state_nxt    = ST_UNSYNC;
          w_sync_cnt_nxt = '0;
          w_misalign     = 1'b1;
        end else if (!r_bcr && w_bx_wrap) begin
          w_state_nxt    = ST_UNSYNC;
          w_sync_cnt_nxt = '0;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt    = ST_UNSYNC;
        w_sync_cnt_nxt = '0;
      end
    endcase
  end

  // Pipeline, command pulses, BX counter and lock state.
  always_ff @(posedge clk_bx) begin
    if (reset) begin
      r_enc          <= 16'h0000;
      r_bcr          <= 1'b0;
      r_l1a          <= 1'b0;
      r_link_reset   <= 1'b0;
      r_buffer_clear <= 1'b0;
      r_calib        <= 1'b0;
      r_bit5_prev    <= 1'b0;
      r_bx           <= 12'd0;
      r_state        <= ST_UNSYNC;
      r_sync_cnt     <= '0;
      r_locked       <= 1'b0;
    end else begin
      r_enc          <= fc_stream_enc;
      r_bcr          <= w_fc[0];
      r_l1a          <= w_fc[1];
      r_link_reset   <= w_fc[2];
      r_buffer_clear <= w_fc[3];
      r_calib        <= w_fc[5] & ~r_bit5_prev;
      r_bit5_prev    <= w_fc[5];
      r_bx           <= r_bcr ? 12'd0 : w_bx_free;
      r_state        <= w_state_nxt;
      r_sync_cnt     <= w_sync_cnt_nxt;
      r_locked       <= (w_state_nxt == ST_LOCKED);
    end
  end

  // Counters; a clear wins over any increment in the same cycle.
  always_ff @(posedge clk_bx) begin
    if (reset || cnt_clear) begin
      r_sec      <= '0;
      r_ded      <= '0;
      r_l1a_cnt  <= 32'd0;
      r_misalign <= 16'd0;
    end else begin
      r_sec      <= sat_add(r_sec, w_sec_inc);
      r_ded      <= sat_add(r_ded, {1'b0, w_ded});
      r_l1a_cnt  <= r_l1a_cnt + {31'd0, r_l1a & r_locked};
      r_misalign <= r_misalign + {15'd0, w_misalign};
    end
  end

  assign bcr            = r_bcr;
  assign l1a            = r_l1a;
  assign link_reset     = r_link_reset;
  assign buffer_clear   = r_buffer_clear;
  assign calib_start    = r_calib;
  assign bx_id          = r_bx;
  assign locked         = r_locked;
  assign sec_count      = r_sec;
  assign ded_count      = r_ded;
  assign l1a_count      = r_l1a_cnt;
  assign misalign_count = r_misalign;

endmodule

// File: tb/tb_fast_control_rx.sv
// Directed bench for fast_control_rx: lock acquisition, SECDED handling,
// calibration edge detection, counter saturation/clear and reset behaviour.
module tb_fast_control_rx;

  logic        clk_bx = 1'b0;
  logic        reset;
  logic [15:0] fc_stream_enc;
  logic [11:0] orb_length;
  logic        cnt_clear;
  logic        bcr, l1a, link_reset, buffer_clear, calib_start, locked;
  logic [11:0] bx_id;
  logic [15:0] sec_count, ded_count, misalign_count;
  logic [31:0] l1a_count;

  int n_pass  = 0;
  int n_total = 0;
  int n_calib;

  localparam logic [15:0] W_BCR     = 16'h00B1;
  localparam logic [15:0] W_L1A     = 16'h00D2;
  localparam logic [15:0] W_L1A_SEC = 16'h00D3;  // d0 flipped
  localparam logic [15:0] W_L1A_DED = 16'h00D1;  // d0 and d1 flipped
  localparam logic [15:0] W_CAL     = 16'hD200;
  localparam logic [15:0] W_CAL_DED = 16'hD100;
  localparam logic [15:0] W_SEC2    = 16'h0101;  // both bytes carry one flipped bit

  fast_control_rx dut (
    .clk_bx(clk_bx), .reset(reset), .fc_stream_enc(fc_stream_enc),
    .orb_length(orb_length), .cnt_clear(cnt_clear),
    .bcr(bcr), .l1a(l1a), .link_reset(link_reset), .buffer_clear(buffer_clear),
    .calib_start(calib_start), .bx_id(bx_id), .locked(locked),
    .sec_count(sec_count), .ded_count(ded_count),
    .l1a_count(l1a_count), .misalign_count(misalign_count)
  );

  always #5 clk_bx = ~clk_bx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic [15:0] w);
    fc_stream_enc = w;
    @(posedge clk_bx);
    #1;
  endtask

  // One aligned BCR: its pulse lands when bx_id is orb_length-1.
  task automatic bcr_cycle(input string tag);
    repeat (42) step(16'h0000);
    step(W_BCR);
    step(16'h0000);
    chk({tag, "_bcr"}, {31'd0, bcr}, 32'd1);
    chk({tag, "_bx44"}, {20'd0, bx_id}, 32'd44);
    step(16'h0000);
    chk({tag, "_bx0"}, {20'd0, bx_id}, 32'd0);
  endtask

  task automatic first_bcr(input string tag);
    step(W_BCR);
    step(16'h0000);
    chk({tag, "_pulse"}, {31'd0, bcr}, 32'd1);
    step(16'h0000);
    chk({tag, "_bx0"}, {20'd0, bx_id}, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    cnt_clear     = 1'b0;
    orb_length    = 12'd45;
    fc_stream_enc = 16'h0000;
    repeat (3) @(posedge clk_bx);
    #1;
    chk("rst_outputs", {bcr, l1a, link_reset, buffer_clear, calib_start, locked, bx_id},
        32'd0);
    chk("rst_counters", {sec_count, ded_count} | l1a_count | {16'd0, misalign_count}, 32'd0);
    reset = 1'b0;

    // Lock acquisition: third BCR locks
    first_bcr("bcr1");
    chk("bcr1_unlocked", {31'd0, locked}, 32'd0);
    bcr_cycle("bcr2");
    chk("bcr2_unlocked", {31'd0, locked}, 32'd0);
    bcr_cycle("bcr3");
    chk("bcr3_locked", {31'd0, locked}, 32'd1);

    // Clean, corrected and uncorrectable L1A words while locked
    step(W_L1A);
    step(16'h0000);
    chk("l1a_pulse", {31'd0, l1a}, 32'd1);
    chk("l1a_errs", {sec_count, ded_count}, 32'd0);
    step(16'h0000);
    chk("l1a_count1", l1a_count, 32'd1);
    chk("l1a_gone", {31'd0, l1a}, 32'd0);
    step(W_L1A_SEC);
    step(16'h0000);
    chk("sec_l1a", {31'd0, l1a}, 32'd1);
    chk("sec_count1", {16'd0, sec_count}, 32'd1);
    step(16'h0000);
    chk("sec_l1a_count", l1a_count, 32'd2);
    step(W_L1A_DED);
    step(16'h0000);
    chk("ded_no_cmd", {28'd0, bcr, l1a, link_reset, buffer_clear}, 32'd0);
    chk("ded_count1", {16'd0, ded_count}, 32'd1);
    chk("ded_sec_same", {16'd0, sec_count}, 32'd1);
    step(16'h0000);
    chk("ded_l1a_count", l1a_count, 32'd2);

    // Misplaced BCR at bx_id 20 drops lock
    repeat (9) step(16'h0000);
    step(W_BCR);
    step(16'h0000);
    chk("mis_bcr", {31'd0, bcr}, 32'd1);
    chk("mis_bx20", {20'd0, bx_id}, 32'd20);
    step(16'h0000);
    chk("mis_unlock", {31'd0, locked}, 32'd0);
    chk("mis_count", {16'd0, misalign_count}, 32'd1);
    chk("mis_bx0", {20'd0, bx_id}, 32'd0);

    // L1A while unlocked pulses but is not counted
    step(W_L1A);
    step(16'h0000);
    chk("unl_l1a", {31'd0, l1a}, 32'd1);
    step(16'h0000);
    chk("unl_l1a_count", l1a_count, 32'd2);

    // Calibration edge: four bit5 words give one pulse
    n_calib = 0;
    for (int i = 0; i < 7; i++) begin
      step((i < 4) ? W_CAL : 16'h0000);
      n_calib += int'(calib_start);
    end
    chk("calib_once", n_calib, 32'd1);
    // A DED word between bit5 words re-arms the edge detector
    n_calib = 0;
    step(W_CAL);
    n_calib += int'(calib_start);
    step(W_CAL_DED);
    n_calib += int'(calib_start);
    for (int i = 0; i < 4; i++) begin
      step((i == 0) ? W_CAL : 16'h0000);
      n_calib += int'(calib_start);
    end
    chk("calib_ded_twice", n_calib, 32'd2);
    chk("calib_ded_count", {16'd0, ded_count}, 32'd2);

    // Double-byte SEC words, then saturation
    repeat (100) step(W_SEC2);
    step(16'h0000);
    chk("sec_plus2", {16'd0, sec_count}, 32'd201);
    repeat (32767) step(W_SEC2);
    step(16'h0000);
    step(16'h0000);
    chk("sec_saturated", {16'd0, sec_count}, 32'h0000FFFF);
    step(W_SEC2);
    step(16'h0000);
    chk("sec_stays_sat", {16'd0, sec_count}, 32'h0000FFFF);

    // Clear wins over a simultaneous increment
    step(W_SEC2);
    cnt_clear = 1'b1;
    step(16'h0000);
    cnt_clear = 1'b0;
    chk("clr_sec", {16'd0, sec_count}, 32'd0);
    chk("clr_others", {16'd0, ded_count} | l1a_count | {16'd0, misalign_count}, 32'd0);
    step(16'h0000);
    chk("clr_sec_after", {16'd0, sec_count}, 32'd0);

    // Relock, then lose lock on a missing BCR at wrap
    first_bcr("re1");
    bcr_cycle("re2");
    bcr_cycle("re3");
    chk("re_locked", {31'd0, locked}, 32'd1);
    repeat (44) step(16'h0000);
    chk("miss_still_locked", {31'd0, locked}, 32'd1);
    step(16'h0000);
    chk("miss_unlock", {31'd0, locked}, 32'd0);
    chk("miss_bx0", {20'd0, bx_id}, 32'd0);
    chk("miss_no_misalign", {16'd0, misalign_count}, 32'd0);

    // Reset mid-lock
    first_bcr("rl1");
    bcr_cycle("rl2");
    bcr_cycle("rl3");
    chk("rl_locked", {31'd0, locked}, 32'd1);
    step(W_L1A);
    reset = 1'b1;
    step(16'h0000);
    reset = 1'b0;
    chk("rst_unlock", {31'd0, locked}, 32'd0);
    chk("rst_bx", {20'd0, bx_id}, 32'd0);
    chk("rst_l1a", {31'd0, l1a}, 32'd0);
    step(W_BCR);
    step(16'h0000);
    chk("post_rst_decode", {31'd0, bcr}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
